// File: rtl/morra_match_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : morra_match_controller_if
// Brief    : Player, evaluator and status signals of the Morra match controller.
// Revision : 1.0 - initial release
// ============================================================================
interface morra_match_controller_if #(
  parameter int CFG_W = 4
);
  logic             CONFIG_VALID;
  logic [CFG_W-1:0] CONFIG;
  logic             P1_VALID;
  logic [1:0]       P1_MOVE;
  logic             P1_READY;
  logic             P2_VALID;
  logic [1:0]       P2_MOVE;
  logic             P2_READY;
  logic             EVAL_VALID;
  logic [1:0]       EVAL_P1;
  logic [1:0]       EVAL_P2;
  logic             EVAL_READY;
  logic             RES_VALID;
  logic [1:0]       RES;
  logic [1:0]       MANCHE;
  logic             MANCHE_VALID;
  logic [1:0]       PARTITA;
  logic [4:0]       ROUND;
  logic             ERRORE;

  modport master (
    output CONFIG_VALID, CONFIG, P1_VALID, P1_MOVE, P2_VALID, P2_MOVE,
           EVAL_READY, RES_VALID, RES,
    input  P1_READY, P2_READY, EVAL_VALID, EVAL_P1, EVAL_P2,
           MANCHE, MANCHE_VALID, PARTITA, ROUND, ERRORE
  );

  modport slave (
    input  CONFIG_VALID, CONFIG, P1_VALID, P1_MOVE, P2_VALID, P2_MOVE,
           EVAL_READY, RES_VALID, RES,
    output P1_READY, P2_READY, EVAL_VALID, EVAL_P1, EVAL_P2,
           MANCHE, MANCHE_VALID, PARTITA, ROUND, ERRORE
  );
endinterface
`default_nettype wire

// File: rtl/morra_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : morra_match_controller
// Brief    : Collects player moves, drives the round evaluator, scores the match.
// Revision : 1.0 - initial release
// ============================================================================
module morra_match_controller #(
  parameter int MINROUNDS = 4,
  parameter int CFG_W     = 4
) (
  input  wire logic clk,
  input  wire logic INIZIA,
  morra_match_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_SETUP    = 3'd0,
    S_COLLECT  = 3'd1,
    S_EVAL     = 3'd2,
    S_WAIT_RES = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [4:0] c_minrounds = 5'(MINROUNDS);

  state_t     r_state, w_state_n;
  logic       r_slot1, w_slot1_n, r_slot2, w_slot2_n;
  logic [1:0] r_mv1, w_mv1_n, r_mv2, w_mv2_n;
  logic [4:0] r_wins1, w_wins1_n, r_wins2, w_wins2_n;
  logic [4:0] r_round, w_round_n, r_length, w_length_n;
  logic [1:0] r_manche, w_manche_n, r_partita, w_partita_n;
  logic       r_manche_valid, w_manche_valid_n, r_errore, w_errore_n;
  logic       r_p1_ready, w_p1_ready_n, r_p2_ready, w_p2_ready_n;
  logic       r_eval_valid, w_eval_valid_n;

  logic [4:0] w_new_round, w_new_w1, w_new_w2, w_diff;
  logic       w_match_end;

  always_ff @(posedge clk or posedge INIZIA) begin
    if (INIZIA) begin
      r_state        <= S_SETUP;
      r_slot1        <= 1'b0;
      r_slot2        <= 1'b0;
      r_mv1          <= 2'b00;
      r_mv2          <= 2'b00;
      r_wins1        <= 5'd0;
      r_wins2        <= 5'd0;
      r_round        <= 5'd0;
      r_length       <= 5'd0;
      r_manche       <= 2'b00;
      r_partita      <= 2'b00;
      r_manche_valid <= 1'b0;
      r_errore       <= 1'b0;
      r_p1_ready     <= 1'b0;
      r_p2_ready     <= 1'b0;
      r_eval_valid   <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_slot1        <= w_slot1_n;
      r_slot2        <= w_slot2_n;
      r_mv1          <= w_mv1_n;
      r_mv2          <= w_mv2_n;
      r_wins1        <= w_wins1_n;
      r_wins2        <= w_wins2_n;
      r_round        <= w_round_n;
      r_length       <= w_length_n;
      r_manche       <= w_manche_n;
      r_partita      <= w_partita_n;
      r_manche_valid <= w_manche_valid_n;
      r_errore       <= w_errore_n;
      r_p1_ready     <= w_p1_ready_n;
      r_p2_ready     <= w_p2_ready_n;
      r_eval_valid   <= w_eval_valid_n;
    end
  end

  // Score as it would stand if the presented result were accepted this cycle
  always_comb begin
    w_new_round = r_round + 5'd1;
    w_new_w1    = r_wins1 + {4'd0, bus.RES == 2'b01};
    w_new_w2    = r_wins2 + {4'd0, bus.RES == 2'b10};
    w_diff      = (w_new_w1 >= w_new_w2) ? (w_new_w1 - w_new_w2) : (w_new_w2 - w_new_w1);
    w_match_end = ((w_new_round >= c_minrounds) && (w_diff >= 5'd2)) ||
                  (w_new_round == r_length);
  end

  always_comb begin
    w_state_n        = r_state;
    w_slot1_n        = r_slot1;
    w_slot2_n        = r_slot2;
    w_mv1_n          = r_mv1;
    w_mv2_n          = r_mv2;
    w_wins1_n        = r_wins1;
    w_wins2_n        = r_wins2;
    w_round_n        = r_round;
    w_length_n       = r_length;
    w_manche_n       = r_manche;
    w_partita_n      = r_partita;
    w_manche_valid_n = 1'b0;
    w_errore_n       = 1'b0;

    case (r_state)
      S_SETUP, S_DONE: begin
        if (bus.CONFIG_VALID) begin
          w_length_n  = c_minrounds + 5'(bus.CONFIG);
          w_round_n   = 5'd0;
          w_wins1_n   = 5'd0;
          w_wins2_n   = 5'd0;
          w_partita_n = 2'b00;
          w_manche_n  = 2'b00;
          w_slot1_n   = 1'b0;
          w_slot2_n   = 1'b0;
          w_state_n   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A 00 move is consumed (READY was high) but leaves the slot empty
        if (bus.P1_VALID && r_p1_ready) begin
          if (bus.P1_MOVE != 2'b00) begin
            w_slot1_n = 1'b1;
            w_mv1_n   = bus.P1_MOVE;
          end else begin
            w_errore_n = 1'b1;
          end
        end
        if (bus.P2_VALID && r_p2_ready) begin
          if (bus.P2_MOVE != 2'b00) begin
            w_slot2_n = 1'b1;
            w_mv2_n   = bus.P2_MOVE;
          end else begin
            w_errore_n = 1'b1;
          end
        end
        if (w_slot1_n && w_slot2_n) begin
          w_state_n = S_EVAL;
        end
      end
      S_EVAL: begin
        if (bus.EVAL_READY) begin
          w_state_n = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        if (bus.RES_VALID) begin
          w_slot1_n = 1'b0;
          w_slot2_n = 1'b0;
          if (bus.RES == 2'b00) begin
            w_errore_n = 1'b1;
            w_state_n  = S_COLLECT;
          end else begin
            w_manche_n       = bus.RES;
            w_manche_valid_n = 1'b1;
            w_round_n        = w_new_round;
            w_wins1_n        = w_new_w1;
            w_wins2_n        = w_new_w2;
            if (w_match_end) begin
              if (w_new_w1 > w_new_w2)      w_partita_n = 2'b01;
              else if (w_new_w2 > w_new_w1) w_partita_n = 2'b10;
              else                          w_partita_n = 2'b11;
              w_state_n = S_DONE;
            end else begin
              w_state_n = S_COLLECT;
            end
          end
        end
      end
      default: w_state_n = S_SETUP;
    endcase

    // Handshake outputs are registered, so derive them from the next state
    w_p1_ready_n   = (w_state_n == S_COLLECT) && !w_slot1_n;
    w_p2_ready_n   = (w_state_n == S_COLLECT) && !w_slot2_n;
    w_eval_valid_n = (w_state_n == S_EVAL);
  end

  assign bus.P1_READY     = r_p1_ready;
  assign bus.P2_READY     = r_p2_ready;
  assign bus.EVAL_VALID   = r_eval_valid;
  assign bus.EVAL_P1      = r_mv1;
  assign bus.EVAL_P2      = r_mv2;
  assign bus.MANCHE       = r_manche;
  assign bus.MANCHE_VALID = r_manche_valid;
  assign bus.PARTITA      = r_partita;
  assign bus.ROUND        = r_round;
  assign bus.ERRORE       = r_errore;

endmodule
`default_nettype wire

// File: tb/tb_morra_match_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_morra_match_controller
// Brief    : Directed self-checking bench for morra_match_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morra_match_controller;

  logic clk = 1'b0;
  logic INIZIA;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  morra_match_controller_if #(.CFG_W(4)) bus ();

  morra_match_controller #(.MINROUNDS(4), .CFG_W(4)) dut (
    .clk    (clk),
    .INIZIA (INIZIA),
    .bus    (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.CONFIG_VALID = 1'b0; bus.CONFIG = 4'd0;
    bus.P1_VALID = 1'b0; bus.P1_MOVE = 2'b00;
    bus.P2_VALID = 1'b0; bus.P2_MOVE = 2'b00;
    bus.EVAL_READY = 1'b0; bus.RES_VALID = 1'b0; bus.RES = 2'b00;
  endtask

  task automatic start_match(input logic [3:0] cfg);
    bus.CONFIG_VALID = 1'b1; bus.CONFIG = cfg;
    step();
    bus.CONFIG_VALID = 1'b0;
  endtask

  // Minimum-latency round: moves, evaluator handshake, result
  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] res);
    bus.P1_VALID = 1'b1; bus.P1_MOVE = m1; bus.P2_VALID = 1'b1; bus.P2_MOVE = m2;
    step();
    bus.P1_VALID = 1'b0; bus.P2_VALID = 1'b0; bus.EVAL_READY = 1'b1;
    step();
    bus.EVAL_READY = 1'b0; bus.RES_VALID = 1'b1; bus.RES = res;
    step();
    bus.RES_VALID = 1'b0;
  endtask

  task automatic test_reset();
    INIZIA = 1'b1;
    idle_inputs();
    step(); step();
    checks++; if ({bus.P1_READY, bus.P2_READY, bus.EVAL_VALID, bus.MANCHE_VALID, bus.ERRORE} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.P1_READY, bus.P2_READY, bus.EVAL_VALID, bus.MANCHE_VALID, bus.ERRORE}); end
    checks++; if ({bus.MANCHE, bus.PARTITA, bus.ROUND, bus.EVAL_P1, bus.EVAL_P2} !== 13'd0) begin failures++; $display("FAIL reset_values got=%h exp=0", {bus.MANCHE, bus.PARTITA, bus.ROUND, bus.EVAL_P1, bus.EVAL_P2}); end
    INIZIA = 1'b0;
    bus.P1_VALID = 1'b1; bus.P1_MOVE = 2'b01;
    step();
    bus.P1_VALID = 1'b0;
    checks++; if (bus.P1_READY !== 1'b0) begin failures++; $display("FAIL setup_ready got=%b exp=0", bus.P1_READY); end
  endtask

  task automatic test_p1_early_lead();
    start_match(4'd0);
    checks++; if ({bus.P1_READY, bus.P2_READY} !== 2'b11) begin failures++; $display("FAIL start_ready got=%b exp=11", {bus.P1_READY, bus.P2_READY}); end
    play_round(2'b01, 2'b10, 2'b01);
    checks++; if (bus.MANCHE !== 2'b01 || bus.MANCHE_VALID !== 1'b1) begin failures++; $display("FAIL r1_manche got=%b/%b exp=01/1", bus.MANCHE, bus.MANCHE_VALID); end
    checks++; if (bus.ROUND !== 5'd1) begin failures++; $display("FAIL r1_round got=%0d exp=1", bus.ROUND); end
    play_round(2'b01, 2'b10, 2'b01);
    checks++; if (bus.PARTITA !== 2'b00 || bus.ROUND !== 5'd2) begin failures++; $display("FAIL r2_lead_not_final got=%b/%0d exp=00/2", bus.PARTITA, bus.ROUND); end
    checks++; if (bus.P1_READY !== 1'b1) begin failures++; $display("FAIL r2_ready got=%b exp=1", bus.P1_READY); end
    play_round(2'b11, 2'b11, 2'b11);
    checks++; if (bus.PARTITA !== 2'b00 || bus.ROUND !== 5'd3) begin failures++; $display("FAIL r3 got=%b/%0d exp=00/3", bus.PARTITA, bus.ROUND); end
    play_round(2'b10, 2'b10, 2'b11);
    checks++; if (bus.PARTITA !== 2'b01 || bus.ROUND !== 5'd4) begin failures++; $display("FAIL p1_match got=%b/%0d exp=01/4", bus.PARTITA, bus.ROUND); end
    checks++; if ({bus.P1_READY, bus.P2_READY} !== 2'b00) begin failures++; $display("FAIL done_ready got=%b exp=00", {bus.P1_READY, bus.P2_READY}); end
    step();
    checks++; if (bus.MANCHE_VALID !== 1'b0 || bus.PARTITA !== 2'b01 || bus.MANCHE !== 2'b11) begin failures++; $display("FAIL done_hold got=%b/%b/%b exp=0/01/11", bus.MANCHE_VALID, bus.PARTITA, bus.MANCHE); end
  endtask

  task automatic test_draw();
    start_match(4'd2);
    checks++; if (bus.PARTITA !== 2'b00 || bus.ROUND !== 5'd0 || bus.MANCHE !== 2'b00) begin failures++; $display("FAIL restart got=%b/%0d/%b exp=00/0/00", bus.PARTITA, bus.ROUND, bus.MANCHE); end
    for (int i = 0; i < 6; i++) begin
      play_round(2'b01, 2'b11, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 4) begin
        checks++; if (bus.PARTITA !== 2'b00) begin failures++; $display("FAIL draw_r5 got=%b exp=00", bus.PARTITA); end
      end
    end
    checks++; if (bus.PARTITA !== 2'b11 || bus.ROUND !== 5'd6) begin failures++; $display("FAIL draw got=%b/%0d exp=11/6", bus.PARTITA, bus.ROUND); end
    bus.P1_VALID = 1'b1; bus.P2_VALID = 1'b1; bus.P1_MOVE = 2'b01; bus.P2_MOVE = 2'b01;
    step(); step();
    bus.P1_VALID = 1'b0; bus.P2_VALID = 1'b0;
    checks++; if ({bus.P1_READY, bus.P2_READY, bus.EVAL_VALID} !== 3'b000 || bus.ROUND !== 5'd6) begin failures++; $display("FAIL draw_idle got=%b/%0d exp=000/6", {bus.P1_READY, bus.P2_READY, bus.EVAL_VALID}, bus.ROUND); end
  endtask

  task automatic test_p2_early();
    start_match(4'd2);
    for (int i = 0; i < 3; i++) play_round(2'b10, 2'b11, 2'b10);
    checks++; if (bus.PARTITA !== 2'b00 || bus.ROUND !== 5'd3) begin failures++; $display("FAIL p2_r3 got=%b/%0d exp=00/3", bus.PARTITA, bus.ROUND); end
    play_round(2'b10, 2'b11, 2'b10);
    checks++; if (bus.PARTITA !== 2'b10 || bus.ROUND !== 5'd4) begin failures++; $display("FAIL p2_early got=%b/%0d exp=10/4", bus.PARTITA, bus.ROUND); end
  endtask

  task automatic test_invalid_move();
    start_match(4'd15);
    bus.P1_VALID = 1'b1; bus.P1_MOVE = 2'b00;
    step();
    checks++; if (bus.ERRORE !== 1'b1 || bus.P1_READY !== 1'b1 || bus.EVAL_VALID !== 1'b0) begin failures++; $display("FAIL bad_move got=%b%b%b exp=110", bus.ERRORE, bus.P1_READY, bus.EVAL_VALID); end
    bus.P1_MOVE = 2'b01;
    step();
    bus.P1_VALID = 1'b0;
    checks++; if (bus.ERRORE !== 1'b0 || bus.P1_READY !== 1'b0 || bus.P2_READY !== 1'b1) begin failures++; $display("FAIL good_move got=%b%b%b exp=001", bus.ERRORE, bus.P1_READY, bus.P2_READY); end
    bus.P2_VALID = 1'b1; bus.P2_MOVE = 2'b10;
    step();
    bus.P2_VALID = 1'b0;
    checks++; if (bus.EVAL_VALID !== 1'b1 || bus.EVAL_P1 !== 2'b01 || bus.EVAL_P2 !== 2'b10) begin failures++; $display("FAIL eval_pair got=%b/%b/%b exp=1/01/10", bus.EVAL_VALID, bus.EVAL_P1, bus.EVAL_P2); end
    bus.EVAL_READY = 1'b1;
    step();
    bus.EVAL_READY = 1'b0; bus.RES_VALID = 1'b1; bus.RES = 2'b01;
    step();
    bus.RES_VALID = 1'b0;
    checks++; if (bus.ROUND !== 5'd1) begin failures++; $display("FAIL inv_round got=%0d exp=1", bus.ROUND); end
  endtask

  task automatic test_eval_stall();
    bus.P2_VALID = 1'b1; bus.P2_MOVE = 2'b11;
    step();
    checks++; if ({bus.P1_READY, bus.P2_READY} !== 2'b10) begin failures++; $display("FAIL p2_first got=%b exp=10", {bus.P1_READY, bus.P2_READY}); end
    bus.P2_MOVE = 2'b01;
    step();
    bus.P1_VALID = 1'b1; bus.P1_MOVE = 2'b01;
    step();
    checks++; if (bus.EVAL_VALID !== 1'b1 || bus.EVAL_P1 !== 2'b01 || bus.EVAL_P2 !== 2'b11) begin failures++; $display("FAIL stall_pair got=%b/%b/%b exp=1/01/11", bus.EVAL_VALID, bus.EVAL_P1, bus.EVAL_P2); end
    bus.P1_MOVE = 2'b10; bus.P2_MOVE = 2'b10; bus.RES_VALID = 1'b1; bus.RES = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.EVAL_VALID !== 1'b1 || bus.EVAL_P1 !== 2'b01 || bus.EVAL_P2 !== 2'b11 || {bus.P1_READY, bus.P2_READY} !== 2'b00 || bus.ROUND !== 5'd1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%b/%b/%0d exp=1/01/11/00/1", i, bus.EVAL_VALID, bus.EVAL_P1, bus.EVAL_P2, {bus.P1_READY, bus.P2_READY}, bus.ROUND); end
    end
    bus.P1_VALID = 1'b0; bus.P2_VALID = 1'b0; bus.EVAL_READY = 1'b1;
    step();
    bus.EVAL_READY = 1'b0;
    checks++; if (bus.EVAL_VALID !== 1'b0 || bus.MANCHE_VALID !== 1'b0 || bus.ROUND !== 5'd1) begin failures++; $display("FAIL same_cycle_res got=%b/%b/%0d exp=0/0/1", bus.EVAL_VALID, bus.MANCHE_VALID, bus.ROUND); end
    step();
    bus.RES_VALID = 1'b0;
    checks++; if (bus.MANCHE !== 2'b10 || bus.MANCHE_VALID !== 1'b1 || bus.ROUND !== 5'd2 || bus.P1_READY !== 1'b1) begin failures++; $display("FAIL stall_res got=%b/%b/%0d/%b exp=10/1/2/1", bus.MANCHE, bus.MANCHE_VALID, bus.ROUND, bus.P1_READY); end
  endtask

  task automatic test_res_fault();
    play_round(2'b01, 2'b01, 2'b00);
    checks++; if (bus.ERRORE !== 1'b1 || bus.MANCHE_VALID !== 1'b0 || bus.ROUND !== 5'd2 || bus.MANCHE !== 2'b10) begin failures++; $display("FAIL res_fault got=%b/%b/%0d/%b exp=1/0/2/10", bus.ERRORE, bus.MANCHE_VALID, bus.ROUND, bus.MANCHE); end
    checks++; if ({bus.P1_READY, bus.P2_READY} !== 2'b11) begin failures++; $display("FAIL fault_ready got=%b exp=11", {bus.P1_READY, bus.P2_READY}); end
    step();
    checks++; if (bus.ERRORE !== 1'b0) begin failures++; $display("FAIL errore_pulse got=%b exp=0", bus.ERRORE); end
  endtask

  task automatic test_config_ignored();
    bus.CONFIG_VALID = 1'b1; bus.CONFIG = 4'd0;
    step();
    bus.CONFIG_VALID = 1'b0;
    checks++; if (bus.ROUND !== 5'd2 || bus.P1_READY !== 1'b1) begin failures++; $display("FAIL cfg_ignored got=%0d/%b exp=2/1", bus.ROUND, bus.P1_READY); end
    play_round(2'b01, 2'b10, 2'b01);
    checks++; if (bus.ROUND !== 5'd3 || bus.PARTITA !== 2'b00) begin failures++; $display("FAIL cfg_r3 got=%0d/%b exp=3/00", bus.ROUND, bus.PARTITA); end
  endtask

  task automatic test_reset_wait_res();
    bus.P1_VALID = 1'b1; bus.P1_MOVE = 2'b11; bus.P2_VALID = 1'b1; bus.P2_MOVE = 2'b01;
    step();
    bus.P1_VALID = 1'b0; bus.P2_VALID = 1'b0; bus.EVAL_READY = 1'b1;
    step();
    bus.EVAL_READY = 1'b0;
    INIZIA = 1'b1;
    #1;
    checks++; if ({bus.MANCHE, bus.PARTITA, bus.ROUND, bus.EVAL_P1, bus.EVAL_P2} !== 13'd0 || {bus.P1_READY, bus.P2_READY, bus.EVAL_VALID} !== 3'b000) begin failures++; $display("FAIL async_reset got=%h/%b exp=0/000", {bus.MANCHE, bus.PARTITA, bus.ROUND, bus.EVAL_P1, bus.EVAL_P2}, {bus.P1_READY, bus.P2_READY, bus.EVAL_VALID}); end
    step();
    INIZIA = 1'b0; bus.RES_VALID = 1'b1; bus.RES = 2'b01;
    step();
    bus.RES_VALID = 1'b0;
    checks++; if (bus.MANCHE_VALID !== 1'b0 || bus.ROUND !== 5'd0 || bus.MANCHE !== 2'b00) begin failures++; $display("FAIL late_res got=%b/%0d/%b exp=0/0/00", bus.MANCHE_VALID, bus.ROUND, bus.MANCHE); end
    start_match(4'd0);
    checks++; if ({bus.P1_READY, bus.P2_READY} !== 2'b11 || bus.ROUND !== 5'd0) begin failures++; $display("FAIL restart_ready got=%b/%0d exp=11/0", {bus.P1_READY, bus.P2_READY}, bus.ROUND); end
    play_round(2'b11, 2'b10, 2'b10);
    checks++; if (bus.ROUND !== 5'd1 || bus.MANCHE !== 2'b10 || bus.PARTITA !== 2'b00) begin failures++; $display("FAIL restart_round got=%0d/%b/%b exp=1/10/00", bus.ROUND, bus.MANCHE, bus.PARTITA); end
  endtask

  initial begin
    test_reset();
    test_p1_early_lead();
    test_draw();
    test_p2_early();
    test_invalid_move();
    test_eval_stall();
    test_res_fault();
    test_config_ignored();
    test_reset_wait_res();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
